hex_mem_arbiter: RTL and testbench
==================================

Name: hex_mem_arbiter

Overview:
Shares the single byte-wide memory of the hex processor between three requesters: 0 = instruction fetch, 1 = data load/store (LDAM/STAM/LDAI/LDBI/STAI), 2 = SVC/IO unit.
Each granted request becomes a burst of byte accesses on the memory port: 4 beats for a word, 1 for a byte. Words are assembled or split little-endian (byte at addr+0 is bits [7:0]).
Sits between the processor/SVC unit and the memory array. The processor holds its request until it sees the response.

Parameters:
ADDR_W, 12, byte address width; 4096-byte memory.
FIXED_PRIO, 0, 0 = round-robin arbitration; 1 = fixed priority 0 > 1 > 2.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous, active-low reset.
req_valid  in  3  per-requester request; held stable until req_ready.
req_we  in  3  per-requester write enable.
req_byte  in  3  per-requester size; 1 = byte access, 0 = word access.
req_addr  in  3*ADDR_W  per-requester address; requester i occupies slice [i*ADDR_W +: ADDR_W].
req_wdata  in  96  per-requester write data; requester i occupies slice [i*32 +: 32].
req_ready  out  3  one-hot accept pulse.
rsp_valid  out  3  one-hot completion pulse.
rsp_rdata  out  32  read data, shared by all requesters; valid only with rsp_valid.
mem_en  out  1  memory access strobe.
mem_we  out  1  memory write.
mem_addr  out  ADDR_W  memory byte address.
mem_wdata  out  8  memory write byte.
mem_rdata  in  8  memory read byte; valid the cycle after a read strobe.

Behaviour:
- Reset (rst=0): asynchronous; all outputs go to 0 immediately.
  - Internal state: state=IDLE, beat counter=0, rr_last=2, so requester 0 has first priority.
  - An in-flight burst is abandoned: no response, no further memory strobes. Partially written bytes stay in memory.
- States: IDLE, ISSUE, DRAIN, RESP.
- IDLE:
  - If any req_valid bit is set, select a winner w and assert req_ready[w] combinationally in that cycle.
  - On that edge, latch w, we, byte, addr, wdata; set beat=0; go to ISSUE.
  - If no request, stay in IDLE.
- Arbitration:
  - FIXED_PRIO=1: lowest index wins.
  - FIXED_PRIO=0: search order starts at rr_last+1 mod 3 and wraps; rr_last is updated to w on grant.
  - Dropping req_valid before ready is legal and produces no transaction.
- ISSUE: one beat per cycle.
  - mem_en=1, mem_we=we, mem_addr=(addr+beat) mod 2^ADDR_W, mem_wdata=wdata[8*beat +: 8].
  - Beats run 0..3 for a word, 0 only for a byte.
  - After the last beat: write goes to RESP; read goes to DRAIN.
  - mem_en=0 in every other state.
- Read capture: mem_rdata from beat k is captured the following cycle into byte k of the data register.
- DRAIN: one cycle; captures the last byte, then goes to RESP.
- RESP:
  - rsp_valid[w]=1 for exactly one cycle.
  - Reads: rsp_rdata = assembled word; a byte read is zero-extended into [7:0].
  - Writes: rsp_rdata = 0.
  - Next state IDLE, so at most one request is accepted every other cycle.
- Latency, grant at cycle t:
  - Word read: beats t+1..t+4, rsp t+6.
  - Word write: rsp t+5.
  - Byte read: rsp t+3.
  - Byte write: rsp t+2.
- Address wrap: a word at 0xFFE touches bytes 0xFFE, 0xFFF, 0x000, 0x001.
- Outputs outside RESP: rsp_rdata is held at 0.
- Single outstanding burst: requests arriving in ISSUE/DRAIN/RESP wait; req_ready is never asserted outside IDLE.
- Invariants:
  - req_ready and rsp_valid are each at most one-hot.
  - No memory strobe occurs in the grant cycle.

Test Plan:
- Preload mem[0x010..0x013] = 0x78,0x56,0x34,0x12; requester 0 word read at 0x010, granted at t -> mem_en at t+1..t+4 with addr 0x010..0x013; rsp_valid[0] at t+6; rsp_rdata=0x12345678.
- Requester 1 word write 0xDEADBEEF at 0x100 -> mem_wdata EF, BE, AD, DE to 0x100..0x103; rsp_valid[1] at t+5; a following byte read of 0x102 returns 0x000000AD at t'+3.
- All three req_valid held high from reset, FIXED_PRIO=0 -> grant order 0,1,2,0,1; each grant one cycle after the prior RESP.
- Same stimulus with FIXED_PRIO=1 -> requester 0 granted every time, 1 and 2 starved while 0 stays valid.
- Word read at 0xFFE with bytes 0xFFE=0x11, 0xFFF=0x22, 0x000=0x33, 0x001=0x44 -> mem_addr FFE, FFF, 000, 001; rdata=0x44332211.
- Assert rst=0 during beat 2 of a word write -> mem_en and all outputs drop to 0 before the next edge; no rsp_valid; after release, a new request is granted to requester 0 first.

Source files
------------

// File: rtl/hex_mem_arbiter.sv
// hex_mem_arbiter: shares one byte-wide memory between fetch, load/store and SVC requesters as byte bursts
module hex_mem_arbiter #(
    parameter int ADDR_W     = 12,
    parameter int FIXED_PRIO = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [2:0]            req_valid,
    input  logic [2:0]            req_we,
    input  logic [2:0]            req_byte,
    input  logic [3*ADDR_W-1:0]   req_addr,
    input  logic [95:0]           req_wdata,
    output logic [2:0]            req_ready,
    output logic [2:0]            rsp_valid,
    output logic [31:0]           rsp_rdata,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [7:0]            mem_wdata,
    input  logic [7:0]            mem_rdata
);
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, RESP} state_t;
    state_t              r_state, w_next;
    logic [1:0]          r_win, r_rr_last, r_beat, r_cap_idx, w_win, w_start;
    logic                r_we, r_byte, r_cap, w_grant, w_last;
    logic [ADDR_W-1:0]   r_addr;
    logic [31:0]         r_wdata, r_rdata;
    logic [2:0]          w_sum;
    assign w_grant = rst && r_state == IDLE && |req_valid;
    assign w_last  = r_byte || r_beat == 2'd3;
    // pick the first valid requester in search order; lower search offsets overwrite higher ones
    always_comb begin
        w_start = (FIXED_PRIO != 0) ? 2'd0 : (r_rr_last == 2'd2) ? 2'd0 : r_rr_last + 2'd1;
        w_win   = 2'd0;
        w_sum   = 3'd0;
        for (int k = 2; k >= 0; k--) begin
            w_sum = {1'b0, w_start} + 3'(k);
            w_sum = (w_sum >= 3'd3) ? w_sum - 3'd3 : w_sum;
            if (req_valid[w_sum[1:0]]) w_win = w_sum[1:0];
        end
    end
    // next state and all port outputs; everything idles at zero outside its own state
    always_comb begin
        w_next    = r_state;
        req_ready = 3'd0;
        rsp_valid = 3'd0;
        rsp_rdata = 32'd0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = 8'd0;
        case (r_state)
            IDLE: begin
                req_ready = w_grant ? 3'b001 << w_win : 3'd0;
                w_next    = w_grant ? ISSUE : IDLE;
            end
            ISSUE: begin
                mem_en    = 1'b1;
                mem_we    = r_we;
                mem_addr  = r_addr + ADDR_W'(r_beat);
                mem_wdata = r_wdata[{r_beat, 3'b000} +: 8];
                w_next    = !w_last ? ISSUE : r_we ? RESP : DRAIN;
            end
            DRAIN: w_next = RESP;
            RESP: begin
                rsp_valid = 3'b001 << r_win;
                rsp_rdata = r_we ? 32'd0 : r_rdata;
                w_next    = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end
    // state register; reset abandons any burst in flight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_next;
    end
    // request latch, beat counter and read-byte capture one cycle behind each read strobe
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_win     <= 2'd0;
            r_rr_last <= 2'd2;
            r_we      <= 1'b0;
            r_byte    <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= 32'd0;
            r_rdata   <= 32'd0;
            r_beat    <= 2'd0;
            r_cap     <= 1'b0;
            r_cap_idx <= 2'd0;
        end else begin
            r_cap     <= mem_en && !mem_we;
            r_cap_idx <= r_beat;
            if (r_cap) r_rdata[{r_cap_idx, 3'b000} +: 8] <= mem_rdata;
            if (w_grant) begin
                r_win     <= w_win;
                r_rr_last <= w_win;
                r_we      <= req_we[w_win];
                r_byte    <= req_byte[w_win];
                r_addr    <= req_addr[w_win*ADDR_W +: ADDR_W];
                r_wdata   <= req_wdata[{w_win, 5'b00000} +: 32];
                r_beat    <= 2'd0;
                r_rdata   <= 32'd0;
            end else if (r_state == ISSUE) begin
                r_beat <= r_beat + 2'd1;
            end
        end
    end
endmodule

// File: tb/tb_hex_mem_arbiter.sv
// tb_hex_mem_arbiter: directed and random bursts checked against a byte-array memory model
module tb_hex_mem_arbiter;
    logic        clk = 1'b0, rst = 1'b1;
    logic [2:0]  req_valid, req_we, req_byte, req_ready, rsp_valid;
    logic [35:0] req_addr;
    logic [95:0] req_wdata;
    logic [31:0] rsp_rdata;
    logic        mem_en, mem_we;
    logic [11:0] mem_addr;
    logic [7:0]  mem_wdata, mem_rdata = 8'd0;
    logic [2:0]  fp_valid, fp_we, fp_byte, fp_ready, fp_rsp_valid;
    logic [35:0] fp_addr;
    logic [95:0] fp_wdata;
    logic [31:0] fp_rsp_rdata;
    logic        fp_mem_en, fp_mem_we;
    logic [11:0] fp_mem_addr;
    logic [7:0]  fp_mem_wdata;
    logic [7:0]  fp_mem_rdata = 8'd0;
    logic [7:0]  mem [4096];
    logic [7:0]  ref_mem [4096];
    logic [20:0] strobes [$];
    logic [31:0] last_rdata;
    int          errors = 0, checks = 0;

    always #5 clk = ~clk;

    hex_mem_arbiter #(.ADDR_W(12), .FIXED_PRIO(0)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we), .req_byte(req_byte),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready), .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata));

    hex_mem_arbiter #(.ADDR_W(12), .FIXED_PRIO(1)) dut_fp (
        .clk(clk), .rst(rst), .req_valid(fp_valid), .req_we(fp_we), .req_byte(fp_byte),
        .req_addr(fp_addr), .req_wdata(fp_wdata), .req_ready(fp_ready), .rsp_valid(fp_rsp_valid),
        .rsp_rdata(fp_rsp_rdata), .mem_en(fp_mem_en), .mem_we(fp_mem_we), .mem_addr(fp_mem_addr),
        .mem_wdata(fp_mem_wdata), .mem_rdata(fp_mem_rdata));

    // memory array behind the arbiter: synchronous write, read data one cycle after the strobe
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else        mem_rdata <= mem[mem_addr];
        end
    end

    // record every memory strobe away from the active edge
    always @(negedge clk) begin
        if (mem_en) strobes.push_back({mem_we, mem_addr, mem_wdata});
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_txn(input int r, input bit we, input bit byt, input logic [11:0] a,
                          input logic [31:0] wd, input logic [2:0] extra);
        int nb, lat, el;
        logic [31:0] er;
        logic [11:0] ea;
        @(negedge clk);
        req_valid = 3'(1 << r) | extra;
        req_we[r] = we;
        req_byte[r] = byt;
        req_addr[r*12 +: 12] = a;
        req_wdata[r*32 +: 32] = wd;
        strobes.delete();
        #1 chk("req_ready", 64'(req_ready), 64'(1 << r));
        nb = byt ? 1 : 4;
        el = byt ? (we ? 2 : 3) : (we ? 5 : 6);
        er = 32'd0;
        if (!we) for (int k = 0; k < nb; k++) er |= 32'(ref_mem[12'(a + 12'(k))]) << (8 * k);
        @(negedge clk);
        req_valid = 3'd0;
        lat = 0;
        for (int c = 1; c <= 20; c++) begin
            if (rsp_valid != 3'd0) begin
                lat = c;
                break;
            end
            @(negedge clk);
        end
        chk("latency", 64'(lat), 64'(el));
        chk("rsp_valid", 64'(rsp_valid), 64'(1 << r));
        chk("rsp_rdata", 64'(rsp_rdata), 64'(er));
        last_rdata = rsp_rdata;
        chk("beat_count", 64'(strobes.size()), 64'(nb));
        for (int k = 0; k < nb && k < strobes.size(); k++) begin
            ea = 12'(a + 12'(k));
            chk("strobe", 64'(strobes[k]), 64'({we, ea, wd[8*k +: 8]}));
        end
        if (we) for (int k = 0; k < nb; k++) ref_mem[12'(a + 12'(k))] = wd[8*k +: 8];
    endtask

    initial begin
        logic [2:0] g [5], fg [5];
        int gc [5];
        int n, fn, seen;
        logic [2:0] exp_rr [5];
        exp_rr = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010};
        req_valid = 3'd0; req_we = 3'd0; req_byte = 3'd0; req_addr = '0; req_wdata = '0;
        fp_valid = 3'd0; fp_we = 3'd0; fp_byte = 3'd0; fp_addr = '0; fp_wdata = '0;
        for (int i = 0; i < 4096; i++) begin
            mem[i] = 8'($urandom);
            ref_mem[i] = mem[i];
        end
        #1 rst = 1'b0;
        req_valid = 3'b111;
        fp_valid = 3'b111;
        #11;
        chk("reset_outputs", 64'({req_ready, rsp_valid, rsp_rdata, mem_en, mem_we, mem_addr, mem_wdata}), 64'd0);
        chk("reset_fp_ready", 64'({fp_ready, fp_rsp_valid, fp_mem_en}), 64'd0);
        req_valid = 3'd0;
        fp_valid = 3'd0;
        @(negedge clk);
        rst = 1'b1;

        // all three requesters held valid: round-robin vs fixed priority
        @(negedge clk);
        req_valid = 3'b111; req_byte = 3'b111; req_we = 3'b000;
        fp_valid = 3'b111; fp_byte = 3'b111; fp_we = 3'b111;
        n = 0; fn = 0;
        for (int c = 0; c < 60 && (n < 5 || fn < 5); c++) begin
            #1;
            if (req_ready != 3'd0 && n < 5) begin
                g[n] = req_ready; gc[n] = c; n++;
            end
            if (fp_ready != 3'd0 && fn < 5) begin
                fg[fn] = fp_ready; fn++;
            end
            @(negedge clk);
        end
        chk("rr_grants", 64'(n), 64'd5);
        chk("fp_grants", 64'(fn), 64'd5);
        for (int i = 0; i < n; i++) chk("rr_order", 64'(g[i]), 64'(exp_rr[i]));
        for (int i = 1; i < n; i++) chk("rr_spacing", 64'(gc[i] - gc[i-1]), 64'd4);
        for (int i = 0; i < fn; i++) chk("fp_order", 64'(fg[i]), 64'(3'b001));
        @(negedge clk);
        req_valid = 3'd0;
        fp_valid = 3'b110;
        seen = 0;
        for (int c = 0; c < 20; c++) begin
            #1;
            if (fp_ready != 3'd0) begin
                seen = 1;
                chk("fp_after_drop", 64'(fp_ready), 64'(3'b010));
                break;
            end
            @(negedge clk);
        end
        chk("fp_after_drop_seen", 64'(seen), 64'd1);
        @(negedge clk);
        fp_valid = 3'd0;
        repeat (8) @(negedge clk);

        // directed transactions
        for (int i = 0; i < 4; i++) begin
            mem[12'h010 + i] = 8'h78 - 8'(i * 8'h22);
            ref_mem[12'h010 + i] = mem[12'h010 + i];
        end
        do_txn(0, 1'b0, 1'b0, 12'h010, 32'h0, 3'd0);
        chk("word_read", 64'(last_rdata), 64'h12345678);
        do_txn(1, 1'b1, 1'b0, 12'h100, 32'hDEADBEEF, 3'd0);
        chk("word_write_rsp", 64'(last_rdata), 64'd0);
        do_txn(1, 1'b0, 1'b1, 12'h102, 32'h0, 3'd0);
        chk("byte_read", 64'(last_rdata), 64'h000000AD);
        mem[12'hFFE] = 8'h11; mem[12'hFFF] = 8'h22; mem[12'h000] = 8'h33; mem[12'h001] = 8'h44;
        ref_mem[12'hFFE] = 8'h11; ref_mem[12'hFFF] = 8'h22; ref_mem[12'h000] = 8'h33; ref_mem[12'h001] = 8'h44;
        do_txn(2, 1'b0, 1'b0, 12'hFFE, 32'h0, 3'd0);
        chk("wrap_read", 64'(last_rdata), 64'h44332211);

        // random mix of requesters, sizes, directions and addresses including the wrap region
        for (int i = 0; i < 24; i++) begin
            do_txn(int'($urandom_range(0, 2)), 1'($urandom), 1'($urandom),
                   ($urandom_range(0, 3) == 0) ? 12'hFFC + 12'($urandom_range(0, 3)) : 12'($urandom),
                   $urandom, 3'd0);
        end

        // reset during beat 2 of a word write
        @(negedge clk);
        req_valid = 3'b010; req_we[1] = 1'b1; req_byte[1] = 1'b0;
        req_addr[12 +: 12] = 12'h200; req_wdata[32 +: 32] = 32'hCAFEF00D;
        @(negedge clk);
        req_valid = 3'd0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midreset_outputs", 64'({req_ready, rsp_valid, rsp_rdata, mem_en, mem_we, mem_addr, mem_wdata}), 64'd0);
        ref_mem[12'h200] = 8'h0D;
        ref_mem[12'h201] = 8'hF0;
        @(negedge clk);
        chk("midreset_byte0", 64'(mem[12'h200]), 64'(ref_mem[12'h200]));
        chk("midreset_byte1", 64'(mem[12'h201]), 64'(ref_mem[12'h201]));
        chk("midreset_byte2", 64'(mem[12'h202]), 64'(ref_mem[12'h202]));
        chk("midreset_no_rsp", 64'(rsp_valid), 64'd0);
        rst = 1'b1;
        do_txn(0, 1'b0, 1'b1, 12'h200, 32'h0, 3'b100);
        chk("post_reset_read", 64'(last_rdata), 64'h0000000D);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
